init_reg_seq: RTL and testbench

//  Sensor register-init sequencer, directly downstream of the power-up init timer.
//  The o_init_update pulse from that timer drives i_init_update here.
//  On that pulse the block walks an external sync ROM of {reg_addr, reg_data} entries.

---
 rtl/init_reg_seq_pkg.sv | 29 ++
 rtl/init_reg_seq_timer.sv | 39 +++
 rtl/init_reg_seq.sv | 194 +++++++++++++++++++
 tb/tb_init_reg_seq.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/init_reg_seq_pkg.sv
// Shared types and constants for the sensor register-init sequencer.
// Holds the state encoding, error codes and the end-of-table marker.
package init_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_ISSUE = 3'd3,
    ST_WAIT  = 3'd4,
    ST_GAP   = 3'd5,
    ST_DONE  = 3'd6,
    ST_ERR   = 3'd7
  } state_e;

  localparam logic [3:0] ERR_NONE    = 4'd0;
  localparam logic [3:0] ERR_NACK    = 4'd1;
  localparam logic [3:0] ERR_TIMEOUT = 4'd2;
  localparam logic [3:0] ERR_EMPTY   = 4'd3;

  localparam int unsigned WD_REG_ADDR_DEF = 16;
  localparam logic [WD_REG_ADDR_DEF-1:0] END_MARK = '1;

  // Counter width helper that never collapses to zero bits.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 32'd2) ? 32'd1 : $clog2(v);
  endfunction

endpackage

// File: rtl/init_reg_seq_timer.sv
// Loadable down-counter with a zero flag; shared between the post-write
// gap and the write-completion timeout since the two never overlap.
module init_seq_timer #(
  parameter int unsigned WD_CNT = 17
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              load_i,
  input  logic [WD_CNT-1:0] load_val_i,
  input  logic              dec_i,
  output logic              zero_o
);

  logic [WD_CNT-1:0] cnt_q, cnt_d;

  // Next count: load wins over decrement; saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - WD_CNT'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/init_reg_seq.sv
// Sensor register-init sequencer: walks a sync ROM of {addr,data} entries
// and issues each as a write to the SCCB/I2C master, with retry and timeout.
module init_reg_seq
  import init_pkg::*;
#(
  parameter int unsigned NB_REG_NUM  = 256,
  parameter int unsigned WD_REG_ADDR = 16,
  parameter int unsigned WD_REG_DATA = 8,
  parameter int unsigned NB_RETRY    = 3,
  parameter int unsigned NB_GAP_CLK  = 1000,
  parameter int unsigned NB_TIMEOUT  = 100000,
  parameter int unsigned WD_ERR_INFO = 4,
  localparam int unsigned WD_IDX     = $clog2(NB_REG_NUM)
) (
  input  logic                           i_sys_clk,
  input  logic                           i_sys_resetn,
  input  logic                           i_init_update,
  output logic [WD_IDX-1:0]              o_tab_addr,
  input  logic [WD_REG_ADDR+WD_REG_DATA-1:0] i_tab_data,
  output logic                           m_wr_valid,
  input  logic                           m_wr_ready,
  output logic [WD_REG_ADDR-1:0]         m_wr_addr,
  output logic [WD_REG_DATA-1:0]         m_wr_data,
  input  logic                           s_wr_done,
  input  logic                           s_wr_nack,
  output logic                           o_init_busy,
  output logic                           o_init_done,
  output logic [WD_ERR_INFO-1:0]         m_err_init_info1
);

  localparam int unsigned TMR_MAX = (NB_GAP_CLK > NB_TIMEOUT) ? NB_GAP_CLK : NB_TIMEOUT;
  localparam int unsigned WD_TMR  = clog2_min1(TMR_MAX + 32'd1);
  localparam int unsigned WD_RTY  = clog2_min1(NB_RETRY);
  // Timeout loads one less so the error lands exactly NB_TIMEOUT clocks after the handshake.
  localparam logic [WD_TMR-1:0] TMR_TO  = WD_TMR'(NB_TIMEOUT - 32'd1);
  localparam logic [WD_TMR-1:0] TMR_GAP = WD_TMR'(NB_GAP_CLK);
  localparam logic [WD_RTY-1:0] RTY_LAST = WD_RTY'(NB_RETRY - 32'd1);
  localparam logic [WD_IDX-1:0] IDX_LAST = WD_IDX'(NB_REG_NUM - 32'd1);

  state_e                   state_q, state_d;
  logic [WD_IDX-1:0]        idx_q, idx_d;
  logic [WD_RTY-1:0]        retry_q, retry_d;
  logic                     valid_q, valid_d;
  logic [WD_REG_ADDR-1:0]   addr_q, addr_d;
  logic [WD_REG_DATA-1:0]   data_q, data_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic [WD_ERR_INFO-1:0]   err_q, err_d;

  logic                     tmr_load_s, tmr_dec_s, tmr_zero_s;
  logic [WD_TMR-1:0]        tmr_val_s;
  logic [WD_REG_ADDR-1:0]   tab_addr_s;
  logic [WD_REG_DATA-1:0]   tab_data_s;

  assign tab_addr_s = i_tab_data[WD_REG_ADDR+WD_REG_DATA-1 -: WD_REG_ADDR];
  assign tab_data_s = i_tab_data[WD_REG_DATA-1:0];

  init_seq_timer #(.WD_CNT(WD_TMR)) u_timer (
    .clk_i      (i_sys_clk),
    .rst_n_i    (i_sys_resetn),
    .load_i     (tmr_load_s),
    .load_val_i (tmr_val_s),
    .dec_i      (tmr_dec_s),
    .zero_o     (tmr_zero_s)
  );

  // Sequencer next-state and registered-output next values.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    retry_d    = retry_q;
    valid_d    = valid_q;
    addr_d     = addr_q;
    data_d     = data_q;
    done_d     = done_q;
    err_d      = err_q;
    busy_d     = 1'b0;
    tmr_load_s = 1'b0;
    tmr_val_s  = '0;
    tmr_dec_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_init_update) begin
          state_d = ST_FETCH;
          idx_d   = '0;
          done_d  = 1'b0;
          err_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: state_d = ST_LOAD;
      ST_LOAD: begin
        addr_d = tab_addr_s;
        data_d = tab_data_s;
        if (&tab_addr_s) begin
          if (idx_q == '0) begin
            state_d = ST_ERR;
            err_d   = WD_ERR_INFO'(ERR_EMPTY);
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end else begin
          state_d = ST_ISSUE;
          retry_d = '0;
          valid_d = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (valid_q && m_wr_ready) begin
          valid_d    = 1'b0;
          state_d    = ST_WAIT;
          tmr_load_s = 1'b1;
          tmr_val_s  = TMR_TO;
        end else begin
          valid_d = 1'b1;
        end
      end
      ST_WAIT: begin
        if (s_wr_done) begin
          if (!s_wr_nack) begin
            state_d    = ST_GAP;
            tmr_load_s = 1'b1;
            tmr_val_s  = TMR_GAP;
          end else if (retry_q < RTY_LAST) begin
            retry_d = retry_q + WD_RTY'(1);
            state_d = ST_ISSUE;
            valid_d = 1'b1;
          end else begin
            state_d = ST_ERR;
            err_d   = WD_ERR_INFO'(ERR_NACK);
          end
        end else if (tmr_zero_s) begin
          state_d = ST_ERR;
          err_d   = WD_ERR_INFO'(ERR_TIMEOUT);
        end else begin
          tmr_dec_s = 1'b1;
        end
      end
      ST_GAP: begin
        if (tmr_zero_s) begin
          idx_d = idx_q + WD_IDX'(1);
          if (idx_q == IDX_LAST) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_FETCH;
          end
        end else begin
          tmr_dec_s = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = !(state_d inside {ST_IDLE, ST_DONE, ST_ERR});
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge i_sys_clk) begin
    if (!i_sys_resetn) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      retry_q <= '0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      retry_q <= retry_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign o_tab_addr       = idx_q;
  assign m_wr_valid       = valid_q;
  assign m_wr_addr        = addr_q;
  assign m_wr_data        = data_q;
  assign o_init_busy      = busy_q;
  assign o_init_done      = done_q;
  assign m_err_init_info1 = err_q;

endmodule

// File: tb/tb_init_reg_seq.sv
// Self-checking bench for init_reg_seq: scenario table, hand-written corner
// sequences and randomized runs checked against a table-walk reference model.
module tb_init_reg_seq;
  import init_pkg::*;

  localparam int unsigned NB_REG_NUM  = 8;
  localparam int unsigned WD_REG_ADDR = 16;
  localparam int unsigned WD_REG_DATA = 8;
  localparam int unsigned NB_RETRY    = 3;
  localparam int unsigned NB_GAP_CLK  = 2;
  localparam int unsigned NB_TIMEOUT  = 50;
  localparam int unsigned WD_ERR_INFO = 4;
  localparam int unsigned WD_IDX      = $clog2(NB_REG_NUM);
  localparam int unsigned WD_TAB      = WD_REG_ADDR + WD_REG_DATA;
  localparam int          MAXC        = 3000;

  logic                   clk = 1'b0;
  logic                   resetn;
  logic                   start;
  logic [WD_IDX-1:0]      tab_addr;
  logic [WD_TAB-1:0]      tab_data;
  logic                   m_wr_valid, m_wr_ready;
  logic [WD_REG_ADDR-1:0] m_wr_addr;
  logic [WD_REG_DATA-1:0] m_wr_data;
  logic                   s_wr_done, s_wr_nack;
  logic                   busy, done;
  logic [WD_ERR_INFO-1:0] err;

  always #5 clk = ~clk;

  init_reg_seq #(
    .NB_REG_NUM(NB_REG_NUM), .WD_REG_ADDR(WD_REG_ADDR), .WD_REG_DATA(WD_REG_DATA),
    .NB_RETRY(NB_RETRY), .NB_GAP_CLK(NB_GAP_CLK), .NB_TIMEOUT(NB_TIMEOUT),
    .WD_ERR_INFO(WD_ERR_INFO)
  ) dut (
    .i_sys_clk(clk), .i_sys_resetn(resetn), .i_init_update(start),
    .o_tab_addr(tab_addr), .i_tab_data(tab_data),
    .m_wr_valid(m_wr_valid), .m_wr_ready(m_wr_ready),
    .m_wr_addr(m_wr_addr), .m_wr_data(m_wr_data),
    .s_wr_done(s_wr_done), .s_wr_nack(s_wr_nack),
    .o_init_busy(busy), .o_init_done(done), .m_err_init_info1(err)
  );

  typedef struct {
    logic [WD_REG_ADDR-1:0] addr;
    logic [WD_REG_DATA-1:0] data;
    int                     cyc;
    bit                     nack;
  } wr_t;

  typedef struct {
    int n_ent; int nack_ent; int nack_num; int mode; int dly; bit mid_start;
    bit exp_done; int exp_err; int exp_wr;
  } row_t;

  logic [WD_TAB-1:0] rom [NB_REG_NUM];
  int  nack_plan [NB_REG_NUM];
  wr_t log_q[$];
  wr_t exp_q[$];
  bit  exp_done;
  int  exp_err;
  int  cyc = 0;
  int  ready_mode = 0, done_dly = 5, hold_cnt = 0;
  bit  stable_ok = 1'b1;
  logic [WD_REG_ADDR-1:0] hold_addr;
  logic [WD_REG_DATA-1:0] hold_data;
  int  start_cyc, end_cyc;
  int  n_vec = 0, n_bad = 0;
  row_t rows [8];

  // Synchronous ROM model: one clock of read latency.
  always @(posedge clk) tab_data <= rom[tab_addr];

  initial forever @(posedge clk) cyc++;

  // SCCB master model: ready pattern, write log, delayed done/nack response.
  initial begin : responder
    bit pend; int pend_cnt; bit pend_nack; int attempt; int idx; wr_t w;
    pend = 1'b0; pend_cnt = 0; pend_nack = 1'b0; attempt = 0;
    s_wr_done = 1'b0; s_wr_nack = 1'b0; m_wr_ready = 1'b0;
    forever begin
      @(negedge clk);
      s_wr_done = 1'b0; s_wr_nack = 1'b0;
      if (resetn !== 1'b1) pend = 1'b0;
      else if (pend) begin
        pend_cnt--;
        if (pend_cnt == 0) begin s_wr_done = 1'b1; s_wr_nack = pend_nack; pend = 1'b0; end
      end
      case (ready_mode)
        1: m_wr_ready = 1'b1;
        2: m_wr_ready = 1'($urandom_range(0, 1));
        3: begin
          if (m_wr_valid && hold_cnt < 10) begin
            if (hold_cnt == 0) begin hold_addr = m_wr_addr; hold_data = m_wr_data; end
            else if (m_wr_addr !== hold_addr || m_wr_data !== hold_data) stable_ok = 1'b0;
            hold_cnt++;
            m_wr_ready = 1'b0;
          end else m_wr_ready = 1'b1;
        end
        default: m_wr_ready = 1'b0;
      endcase
      if (resetn === 1'b1 && m_wr_valid && m_wr_ready) begin
        if (log_q.size() > 0 && log_q[$].addr == m_wr_addr) attempt++;
        else attempt = 1;
        idx = int'(m_wr_addr[7:0]);
        w.addr = m_wr_addr; w.data = m_wr_data; w.cyc = cyc + 1;
        w.nack = (idx < NB_REG_NUM) && (attempt <= nack_plan[idx]);
        log_q.push_back(w);
        if (done_dly != 0) begin pend = 1'b1; pend_cnt = done_dly; pend_nack = w.nack; end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Entries 0..n_ent-1 are writes, entry n_ent is the marker (none if n_ent = depth).
  task automatic fill_rom(input int n_ent, input bit rnd);
    logic [7:0] hi, dat;
    for (int i = 0; i < NB_REG_NUM; i++) begin
      hi  = rnd ? 8'($urandom_range(0, 254)) : 8'(8'h30 + i);
      dat = rnd ? 8'($urandom) : 8'(8'h5A ^ (i * 17));
      if (i == n_ent) rom[i] = {END_MARK, 8'h00};
      else            rom[i] = {hi, 8'(i), dat};
    end
  endtask

  // Reference: walk the table, expand retries, stop on marker or exhausted retries.
  task automatic build_model();
    wr_t e;
    exp_q.delete(); exp_done = 1'b0; exp_err = 0;
    for (int i = 0; i < NB_REG_NUM; i++) begin
      if (rom[i][WD_TAB-1 -: WD_REG_ADDR] == END_MARK) begin
        if (i == 0) exp_err = 3; else exp_done = 1'b1;
        return;
      end
      for (int a = 0; a < NB_RETRY; a++) begin
        e.addr = rom[i][WD_TAB-1 -: WD_REG_ADDR];
        e.data = rom[i][WD_REG_DATA-1:0];
        e.nack = (a < nack_plan[i]);
        e.cyc  = 0;
        exp_q.push_back(e);
        if (!e.nack) break;
      end
      if (nack_plan[i] >= NB_RETRY) begin exp_err = 1; return; end
    end
    exp_done = 1'b1;
  endtask

  task automatic run_seq(input string tag, input int mode, input int dly, input bit mid);
    int k;
    log_q.delete(); hold_cnt = 0; stable_ok = 1'b1; ready_mode = mode; done_dly = dly;
    @(negedge clk); start = 1'b1; start_cyc = cyc;
    @(negedge clk); start = 1'b0;
    chk({tag, "_busy_rise"}, 64'(busy), 64'd1);
    k = 0;
    while (busy && k < MAXC) begin
      @(negedge clk);
      k++;
      start = (mid && k == 16);
    end
    start = 1'b0;
    end_cyc = cyc;
    if (k >= MAXC) begin
      chk({tag, "_run_bound"}, 64'(k), 64'(MAXC - 1));
      resetn = 1'b0; @(negedge clk); resetn = 1'b1;
    end
  endtask

  task automatic cmp_model(input string tag, input bit timing, input int dly, input int hold);
    int n;
    chk({tag, "_done"}, 64'(done), 64'(exp_done));
    chk({tag, "_err"}, 64'(err), 64'(exp_err));
    chk({tag, "_nwr"}, 64'(log_q.size()), 64'(exp_q.size()));
    n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_addr%0d", tag, i), 64'(log_q[i].addr), 64'(exp_q[i].addr));
      chk($sformatf("%s_data%0d", tag, i), 64'(log_q[i].data), 64'(exp_q[i].data));
      if (timing && i == 0)
        chk({tag, "_latency"}, 64'(log_q[0].cyc - start_cyc), 64'(4 + hold));
      else if (timing)
        chk($sformatf("%s_gap%0d", tag, i), 64'(log_q[i].cyc - log_q[i-1].cyc),
            64'(exp_q[i-1].nack ? dly + 1 : dly + NB_GAP_CLK + 4));
    end
  endtask

  initial begin
    int n_ent, mode, dly, k;
    resetn = 1'b0; start = 1'b0;
    for (int i = 0; i < NB_REG_NUM; i++) begin nack_plan[i] = 0; rom[i] = '0; end
    repeat (3) @(negedge clk);
    chk("rst_valid", 64'(m_wr_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_tab_addr", 64'(tab_addr), 64'd0);
    chk("rst_wr_addr", 64'(m_wr_addr), 64'd0);
    resetn = 1'b1;
    @(negedge clk);

    //         n  nent nnum mode dly mid  done err nwr
    rows[0] = '{3, -1, 0, 1, 5, 1'b0, 1'b1, 0, 3};   // plain walk
    rows[1] = '{3,  1, 2, 1, 5, 1'b0, 1'b1, 0, 5};   // two NACKs recovered
    rows[2] = '{3,  0, 3, 1, 5, 1'b0, 1'b0, 1, 3};   // retries exhausted
    rows[3] = '{3,  2, 5, 1, 5, 1'b0, 1'b0, 1, 5};   // exhausted on last entry
    rows[4] = '{3, -1, 0, 1, 0, 1'b0, 1'b0, 2, 1};   // no completion -> timeout
    rows[5] = '{0, -1, 0, 1, 5, 1'b0, 1'b0, 3, 0};   // empty table
    rows[6] = '{8, -1, 0, 1, 2, 1'b0, 1'b1, 0, 8};   // full table, no marker
    rows[7] = '{3, -1, 0, 3, 5, 1'b1, 1'b1, 0, 3};   // ready held low, mid-run start
    for (int r = 0; r < 8; r++) begin
      string tag;
      tag = $sformatf("row%0d", r);
      for (int i = 0; i < NB_REG_NUM; i++) nack_plan[i] = 0;
      if (rows[r].nack_ent >= 0) nack_plan[rows[r].nack_ent] = rows[r].nack_num;
      fill_rom(rows[r].n_ent, 1'b0);
      build_model();
      run_seq(tag, rows[r].mode, rows[r].dly, rows[r].mid_start);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_done_c"}, 64'(done), 64'(rows[r].exp_done));
      chk({tag, "_err_c"}, 64'(err), 64'(rows[r].exp_err));
      chk({tag, "_nwr_c"}, 64'(log_q.size()), 64'(rows[r].exp_wr));
      if (rows[r].dly != 0)
        cmp_model(tag, 1'b1, rows[r].dly, (rows[r].mode == 3) ? 10 : 0);
      else if (log_q.size() > 0)
        chk({tag, "_timeout_clk"}, 64'(end_cyc - log_q[0].cyc), 64'(NB_TIMEOUT));
      if (rows[r].mode == 3) chk({tag, "_held_stable"}, 64'(stable_ok), 64'd1);
      repeat (20) @(negedge clk);
      chk({tag, "_no_more_wr"}, 64'(log_q.size()), 64'(rows[r].exp_wr));
    end

    // Reset while waiting for completion of entry 1, then a clean restart.
    for (int i = 0; i < NB_REG_NUM; i++) nack_plan[i] = 0;
    fill_rom(3, 1'b0);
    log_q.delete(); ready_mode = 1; done_dly = 5;
    @(negedge clk); start = 1'b1; @(negedge clk); start = 1'b0;
    k = 0;
    while (log_q.size() < 2 && k < MAXC) begin @(negedge clk); k++; end
    chk("rst_mid_reach_wait", 64'(log_q.size()), 64'd2);
    @(negedge clk); @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    chk("rst_mid_valid", 64'(m_wr_valid), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_tab_addr", 64'(tab_addr), 64'd0);
    chk("rst_mid_wr_addr", 64'(m_wr_addr), 64'd0);
    resetn = 1'b1;
    build_model();
    run_seq("restart", 1, 5, 1'b0);
    cmp_model("restart", 1'b1, 5, 0);

    // Randomized tables, NACK patterns, ready patterns and done delays.
    for (int t = 0; t < 10; t++) begin
      string tag;
      tag = $sformatf("rnd%0d", t);
      n_ent = $urandom_range(0, NB_REG_NUM);
      mode  = $urandom_range(1, 2);
      dly   = $urandom_range(1, 6);
      for (int i = 0; i < NB_REG_NUM; i++)
        nack_plan[i] = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0;
      fill_rom(n_ent, 1'b1);
      build_model();
      run_seq(tag, mode, dly, 1'b0);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      cmp_model(tag, mode == 1, dly, 0);
      repeat (5) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
